mac_4bit: RTL and testbench

MAC_4BIT -- requirements
Module: mac_4bit

---
 rtl/mac_4bit.sv | 174 +++++++++++++++++
 tb/tb_mac_4bit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_4bit.sv
// mac_4bit: two-stage 4x4 multiply-accumulate that sums groups of N products into ACC_W bits.
// Build option MAC_SATURATE_EN: acc saturates at all-ones on overflow instead of wrapping.

module mul_4x4_array (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] row;
    logic       carry;
    logic       pp;
    logic       sum;

    // Row i adds partial product a*b[i] into bits [i+3:i] with a ripple of full adders.
    always_comb begin
        row   = {4'b0000, a & {4{b[0]}}};
        carry = 1'b0;
        pp    = 1'b0;
        sum   = 1'b0;
        for (int unsigned i = 1; i < 4; i++) begin
            carry = 1'b0;
            for (int unsigned j = 0; j < 4; j++) begin
                pp    = a[2'(j)] & b[2'(i)];
                sum   = row[3'(i + j)] ^ pp ^ carry;
                carry = (row[3'(i + j)] & pp) | (row[3'(i + j)] & carry) | (pp & carry);
                row[3'(i + j)] = sum;
            end
            row[3'(i + 4)] = carry;
        end
        p = row;
    end
endmodule

module mac_4bit #(
    parameter int N     = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic             s1_valid;
    logic [7:0]       product;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum;
    logic [3:0]       cnt;
    logic             ovf_flag;
    logic             group_ovf;
    logic             last;
    logic             xfer;

    assign out_valid = (state == DONE);
    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign last      = (cnt == LAST_CNT);

    mul_4x4_array u_mul (
        .a(s1_a),
        .b(s1_b),
        .p(product)
    );

    // One extra bit captures the carry-out of each addition as the overflow event.
    assign sum       = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, product};
    assign group_ovf = ovf_flag | sum[ACC_W];

    always_comb begin
`ifdef MAC_SATURATE_EN
        acc_next = group_ovf ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_valid <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            acc_out  <= '0;
            ovf      <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (xfer) begin
                s1_a <= a;
                s1_b <= b;
            end
            s1_valid <= xfer;
            if (s1_valid) begin
                if (last) begin
                    acc_out  <= acc_next;
                    ovf      <= group_ovf;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_flag <= 1'b0;
                end else begin
                    acc      <= acc_next;
                    cnt      <= cnt + 4'd1;
                    ovf_flag <= group_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE is left on out_ready unless a new group completes on the same edge.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (s1_valid) begin
                        state_next = last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (s1_valid && last) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (s1_valid && last) begin
                        state_next = DONE;
                    end else if (out_ready) begin
                        state_next = (s1_valid || cnt != 4'd0) ? ACCUM : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= LAST_CNT);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !clear) |=> (out_valid && $stable(acc_out) && $stable(ovf)));
endmodule

// File: tb/tb_mac_4bit.sv
// Randomized and directed bench for mac_4bit with three parameterisations fed the same stimulus.
`timescale 1ns/1ps
module tb_mac_4bit;
    localparam int NI = 3;
    localparam int NS [NI] = '{4, 8, 2};
    localparam int WS [NI] = '{12, 10, 8};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_ready_o  [NI];
    logic       out_valid_o [NI];
    logic       ovf_o       [NI];
    logic [11:0] acc4;
    logic [9:0]  acc8;
    logic [7:0]  acc2;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;
    int seen [NI];

    // Reference model: integer group sums, one-deep operand stage, held result.
    bit          m_s1v [NI];
    int unsigned m_s1p [NI];
    int unsigned m_sum [NI];
    int unsigned m_cnt [NI];
    int unsigned m_acc [NI];
    bit          m_ov  [NI];
    bit          m_ovf [NI];

    always #5 clk = ~clk;

    mac_4bit #(.N(4), .ACC_W(12)) u_n4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .a(a), .b(b), .out_valid(out_valid_o[0]), .out_ready(out_ready), .acc_out(acc4), .ovf(ovf_o[0])
    );
    mac_4bit #(.N(8), .ACC_W(10)) u_n8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .a(a), .b(b), .out_valid(out_valid_o[1]), .out_ready(out_ready), .acc_out(acc8), .ovf(ovf_o[1])
    );
    mac_4bit #(.N(2), .ACC_W(8)) u_n2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .a(a), .b(b), .out_valid(out_valid_o[2]), .out_ready(out_ready), .acc_out(acc2), .ovf(ovf_o[2])
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned acc_of(input int i);
        case (i)
            0:       return 32'(acc4);
            1:       return 32'(acc8);
            default: return 32'(acc2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_s1v[i] = 0; m_s1p[i] = 0; m_sum[i] = 0; m_cnt[i] = 0;
            m_acc[i] = 0; m_ov[i]  = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic model_step();
        bit          take;
        bit          loaded;
        int unsigned maxv;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                maxv   = (32'd1 << WS[i]) - 32'd1;
                take   = in_valid && (!m_ov[i] || out_ready);
                loaded = 0;
                if (clear) begin
                    m_s1v[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_ov[i] = 0;
                end else begin
                    if (m_s1v[i]) begin
                        m_sum[i] += m_s1p[i];
                        m_cnt[i]++;
                        if (m_cnt[i] == 32'(NS[i])) begin
`ifdef MAC_SATURATE_EN
                            m_acc[i] = (m_sum[i] > maxv) ? maxv : m_sum[i];
`else
                            m_acc[i] = m_sum[i] % (maxv + 32'd1);
`endif
                            m_ovf[i] = (m_sum[i] > maxv);
                            m_ov[i]  = 1;
                            m_sum[i] = 0;
                            m_cnt[i] = 0;
                            loaded   = 1;
                        end
                    end
                    if (!loaded && m_ov[i] && out_ready) m_ov[i] = 0;
                    m_s1v[i] = take;
                    if (take) m_s1p[i] = 32'(a) * 32'(b);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NI; i++) if (out_valid_o[i]) seen[i]++;
    endtask

    task automatic drive(input bit v, input int unsigned av, input int unsigned bv);
        in_valid = v; a = 4'(av); b = 4'(bv);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 0; clear = 0; in_valid = 0;
        model_reset();
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < NI; i++) seen[i] = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("u%0d.in_ready", i), 32'(in_ready_o[i]), 32'(!m_ov[i] || out_ready));
                check($sformatf("u%0d.out_valid", i), 32'(out_valid_o[i]), 32'(m_ov[i]));
                check($sformatf("u%0d.acc_out", i), acc_of(i), m_acc[i]);
                check($sformatf("u%0d.ovf", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
            end
        end
    end

    initial begin
        rst_n = 0; clear = 0; in_valid = 0; a = 0; b = 0; out_ready = 1;
        model_reset();
        mon_en = 1;
        tick();
        check("reset.in_ready", 32'(in_ready_o[0]), 1);
        check("reset.out_valid", 32'(out_valid_o[0]), 0);
        check("reset.acc_out", 32'(acc4), 0);
        check("reset.ovf", 32'(ovf_o[0]), 0);

        // Four maximal products: 4 * 225 = 900.
        do_reset(); out_ready = 1;
        repeat (4) drive(1, 15, 15);
        in_valid = 0;
        check("r029.early", 32'(out_valid_o[0]), 0);
        tick();
        check("r029.valid", 32'(out_valid_o[0]), 1);
        check("r029.acc", 32'(acc4), 900);
        check("r029.ovf", 32'(ovf_o[0]), 0);
        tick();
        check("r029.pulse", 32'(out_valid_o[0]), 0);
        check("r029.count", 32'(seen[0]), 1);

        // Held result under back-pressure: 15+0+15+4 = 34.
        do_reset(); out_ready = 0;
        drive(1, 3, 5); drive(1, 0, 9); drive(1, 15, 1); drive(1, 2, 2);
        in_valid = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("r030.acc", 32'(acc4), 34);
            check("r030.valid", 32'(out_valid_o[0]), 1);
            check("r030.in_ready", 32'(in_ready_o[0]), 0);
            drive(1, 7, 7);
        end
        in_valid = 0; out_ready = 1; #1;
        check("r030.release", 32'(in_ready_o[0]), 1);
        tick();
        check("r030.cleared", 32'(out_valid_o[0]), 0);

        // Eight maximal products into 10 bits: 1800 overflows.
        do_reset(); out_ready = 1;
        repeat (8) drive(1, 15, 15);
        in_valid = 0;
        tick();
        check("r031.valid", 32'(out_valid_o[1]), 1);
        check("r031.ovf", 32'(ovf_o[1]), 1);
`ifdef MAC_SATURATE_EN
        check("r031.acc", 32'(acc8), 1023);
`else
        check("r031.acc", 32'(acc8), 776);
`endif

        // Clear flushes a partial group, including the operand still in stage 1.
        do_reset(); out_ready = 1;
        drive(1, 6, 7); drive(1, 9, 9);
        in_valid = 0; clear = 1;
        tick();
        clear = 0;
        repeat (4) drive(1, 1, 1);
        in_valid = 0;
        tick();
        check("r032.acc", 32'(acc4), 4);
        check("r032.valid", 32'(out_valid_o[0]), 1);
        tick();
        check("r032.count", 32'(seen[0]), 1);

        // Asynchronous reset mid-group, away from any clock edge.
        do_reset(); out_ready = 1;
        repeat (7) drive(1, 7, 7);
        in_valid = 0;
        check("r033.pre", 32'(acc4), 196);
        #1; rst_n = 0; model_reset(); #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("r033.acc%0d", i), acc_of(i), 0);
            check($sformatf("r033.valid%0d", i), 32'(out_valid_o[i]), 0);
            check($sformatf("r033.ovf%0d", i), 32'(ovf_o[i]), 0);
            check($sformatf("r033.ready%0d", i), 32'(in_ready_o[i]), 1);
        end
        #3; rst_n = 1;
        for (int i = 0; i < NI; i++) seen[i] = 0;
        repeat (4) drive(1, 2, 3);
        in_valid = 0;
        tick();
        check("r033.acc", 32'(acc4), 24);
        check("r033.count", 32'(seen[0]), 1);

        // Full-rate stream into N=2: a result every other cycle.
        do_reset(); out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            drive(1, 4, 4);
            if (out_valid_o[2]) check("r034.acc", 32'(acc2), 32);
        end
        in_valid = 0;
        tick();
        if (out_valid_o[2]) check("r034.acc", 32'(acc2), 32);
        tick();
        check("r034.count", 32'(seen[2]), 5);

        do_reset();
        for (int c = 0; c < 800; c++) begin
            clear     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a = 4'd15; b = 4'd15;
            end else begin
                a = 4'($urandom); b = 4'($urandom);
            end
            tick();
        end
        clear = 0; in_valid = 0; out_ready = 1;
        repeat (4) tick();

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
